// File: rtl/memctl_pkg.sv
// Shared definitions for the tagged main-memory controller.
//   - Service-register addresses at the top of the word-address space
//   - FSM state and read-source encodings
//   - Default bit position forced high by an atomic write
package memctl_pkg;

  localparam logic [19:0] SVC_SYNDROME = 20'hfffff;
  localparam logic [19:0] SVC_LADDR    = 20'hffffe;
  localparam logic [19:0] SVC_ECCMODE  = 20'hffffd;

  localparam int DEFAULT_RMW_BIT = 55;
  localparam int WORD_W          = 72;  // {tag[7:0], data[63:0]}

  typedef enum logic {IDLE, ARMED} memctl_state_t;

  // Where the read-data outputs come from after the most recent read.
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_SVC} memctl_src_t;

endpackage

// File: rtl/tagged_ram.sv
// Single-port synchronous tag+data store with a registered read port.
// Ports:
//   clk    in   clock
//   addr   in   word address shared by read and write
//   we     in   write enable, wdata commits at the rising edge
//   wdata  in   {tag, data} word to store
//   re     in   read enable; rdata updates only when set, else holds
//   rdata  out  registered read word
// Contents are never reset so the array maps onto block RAM.
module tagged_ram #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/tagged_mem_ctrl.sv
// Tagged main-memory controller answering the CPU external bus.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   o_ad      in   address/data bus (address in low ADDR_W bits on o_astb)
//   o_tag     in   tag stored alongside write data
//   o_astb    in   address strobe (highest priority)
//   o_atomic  in   read-modify-write qualifier: no auto-increment, RMW_BIT set on write
//   o_rd      in   read request (lowest priority)
//   o_wr      in   write request
//   i_data    out  read data, valid one cycle after o_rd, held until next read
//   i_tag     out  read tag
//   err       out  sticky flag: access attempted before any address strobe
module tagged_mem_ctrl
  import memctl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int RMW_BIT = DEFAULT_RMW_BIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] o_ad,
  input  logic [7:0]  o_tag,
  input  logic        o_astb,
  input  logic        o_atomic,
  input  logic        o_rd,
  input  logic        o_wr,
  output logic [63:0] i_data,
  output logic [7:0]  i_tag,
  output logic        err
);

  memctl_state_t     state, state_nxt;
  memctl_src_t       src_p1;
  logic [ADDR_W-1:0] waddr, laddr, acc_addr;
  logic [63:0]       wr_data, svc_data_p1;
  logic [WORD_W-1:0] ram_q;
  logic              do_wr, do_rd, top_page, svc_hit, laddr_hit, err_set;

  // Strobe beats write beats read; only the winner acts.
  assign do_wr = o_wr && !o_astb;
  assign do_rd = o_rd && !o_wr && !o_astb;

  // An unarmed access is still carried out, but at word 0.
  assign acc_addr = (state == IDLE) ? '0 : waddr;

  // Service registers are the top three words: upper bits all ones and
  // low two bits matching one of the service offsets (never 2'b00).
  assign top_page  = &acc_addr[ADDR_W-1:2];
  assign svc_hit   = top_page && (acc_addr[1:0] == SVC_SYNDROME[1:0] ||
                                  acc_addr[1:0] == SVC_LADDR[1:0]    ||
                                  acc_addr[1:0] == SVC_ECCMODE[1:0]);
  assign laddr_hit = top_page && (acc_addr[1:0] == SVC_LADDR[1:0]);

  always_comb begin
    wr_data = o_ad;
    if (o_atomic) wr_data[RMW_BIT] = 1'b1;
  end

  tagged_ram #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_ram (
    .clk   (clk),
    .addr  (acc_addr),
    .we    (do_wr),
    .wdata ({o_tag, wr_data}),
    .re    (do_rd && !svc_hit),
    .rdata (ram_q)
  );

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (o_astb)
      state_nxt = ARMED;
    else if ((o_rd || o_wr) && state == IDLE)
      err_set = 1'b1;
  end

  // Stage p0 -> p1: address/control registers and read-source select
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      waddr  <= '0;
      laddr  <= '0;
      err    <= 1'b0;
      src_p1 <= SRC_ZERO;
    end else begin
      state <= state_nxt;
      if (err_set) err <= 1'b1;
      if (o_astb) begin
        laddr <= waddr;
        waddr <= o_ad[ADDR_W-1:0];
      end else if (do_wr) begin
        if (!o_atomic) waddr <= acc_addr + 1'b1;
      end else if (do_rd) begin
        src_p1 <= svc_hit ? SRC_SVC : SRC_RAM;
        // Service reads park the pointer so a batch stalls at the top.
        if (!svc_hit && !o_atomic) waddr <= acc_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_rd && svc_hit)
      svc_data_p1 <= laddr_hit ? {{(64-ADDR_W){1'b0}}, laddr} : 64'd0;
  end

  // Stage p1: output mux
  always_comb begin
    i_data = '0;
    i_tag  = '0;
    case (src_p1)
      SRC_RAM: begin
        i_data = ram_q[63:0];
        i_tag  = ram_q[71:64];
      end
      SRC_SVC: i_data = svc_data_p1;
      default: ;
    endcase
  end

endmodule

// File: doc/tagged_mem_ctrl.md
# tagged_mem_ctrl

Synthesizable tagged main-memory controller that sits directly downstream of the `cpu` external bus and answers its address-strobe, read, write and read-modify-write cycles. It replaces the behavioural RAM model used in simulation with a registered implementation. It provides:
- a word-address latch with auto-increment for batch transfers;
- a 64-bit data + 8-bit tag store;
- the three memory-service registers at the top of the address space;
- a sticky protocol-error flag.

## Interface
Parameters:
- `ADDR_W`, 20: word-address width; the store holds 2**ADDR_W words.
- `RMW_BIT`, 55: data bit forced to 1 on an atomic write.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `o_ad`  in  64  CPU address/data bus; address in `[ADDR_W-1:0]` when `o_astb`.
- `o_tag`  in  8  CPU tag for writes.
- `o_astb`  in  1  address strobe.
- `o_atomic`  in  1  read-modify-write qualifier.
- `o_rd`  in  1  read request.
- `o_wr`  in  1  write request.
- `i_data`  out  64  read data to CPU.
- `i_tag`  out  8  read tag to CPU.
- `err`  out  1  sticky protocol error.

## Operation
- Priority per cycle: `o_astb`, then `o_wr`, then `o_rd`. Only the highest active request acts; lower ones are ignored.
- `o_astb`:
  - `laddr <= waddr`.
  - `waddr <= o_ad[ADDR_W-1:0]`.
  - FSM goes to ARMED.
- `o_wr`:
  - Store `{o_tag, data}` at `waddr`.
  - data = `o_ad`, except bit `RMW_BIT` is forced to 1 when `o_atomic`.
  - If `!o_atomic`, `waddr <= waddr+1` (wraps modulo 2**ADDR_W).
- `o_rd` at a service address (`waddr` all-ones minus 0/1/2):
  - FFFFF (syndrome): returns 0, tag 0.
  - FFFFE (address latch): returns `laddr` zero-extended, tag 0.
  - FFFFD (ECC mode): returns 0, tag 0.
  - `waddr` does not increment.
- `o_rd` at any other address:
  - Returns stored data and tag.
  - If `!o_atomic`, `waddr` increments.
- Writes to service addresses go to the array like any other address. Service decode applies to reads only.
- FSM states:
  - IDLE (after reset) → ARMED on `o_astb`.
  - ARMED stays ARMED on any access.
  - `o_rd`/`o_wr` while in IDLE sets `err` = 1. The access is still performed, using `waddr` = 0.
- `err` clears only on reset.
- Unwritten locations read as X in simulation. The bench never reads them.

## Timing
- Read latency is 1 cycle. `o_rd` is sampled at edge N; `i_data`/`i_tag` are valid from edge N+1 and hold until the next read.
- Writes commit at the sampling edge. A read of the same address on the next cycle returns the new value, with no bypass hazard.
- Atomic sequence: `o_astb`, then `o_rd`+`o_atomic`, then `o_wr`+`o_atomic` on consecutive cycles. Both accesses hit the same word; `waddr` is unchanged afterwards.
- Back-to-back non-atomic reads or writes stream consecutive words, one per cycle.
- Simultaneous `o_wr` and `o_rd`: the write wins and `i_data` holds its previous value.
- Reset values when `reset_n` = 0 at an edge:
  - `i_data` = 0, `i_tag` = 0, `waddr` = 0, `laddr` = 0, `err` = 0, FSM = IDLE.
  - Array contents are not cleared.
  - Reset in the middle of a batch abandons it; the next access needs a new `o_astb` or it flags `err`.
- Wrap-around: a batch read from 2**ADDR_W−4 passes through the service addresses. Those cycles return service values and do not increment, so `waddr` stays at FFFFD.

## Structure
- `memctl_pkg`:
  - `SVC_SYNDROME` = 'hfffff, `SVC_LADDR` = 'hffffe, `SVC_ECCMODE` = 'hffffd.
  - FSM enum `memctl_state_t {IDLE, ARMED}`.
  - Default `RMW_BIT`.
- Sub-module `tagged_ram`:
  - Single-port synchronous 72-bit × 2**ADDR_W array with one registered read port and one write port.
  - Maps to block RAM.
- Top level holds the address/last-address registers, service decode, output mux and FSM.

## Test plan
- Reset, then `o_astb` with `o_ad` = 'h100, then four writes 'hA0..'hA3 with tag 'h05; then `o_astb` 'h100 and four reads → `i_data` = 'hA0..'hA3, `i_tag` = 'h05, each one cycle after its `o_rd`.
- `o_astb` 'h200, `o_rd`+`o_atomic` of stored 'h0, then `o_wr`+`o_atomic` 'h1 → word 'h200 = 'h0080_0000_0000_0001; the next plain read at 'h200 confirms `waddr` did not increment.
- `o_astb` 'h1234, then `o_astb` 'hffffe, `o_rd` → `i_data` = 'h1234, `i_tag` = 0.
- `o_astb` 'hfffff, `o_rd`; then `o_astb` 'hffffd, `o_rd` → `i_data` = 0 both times; `err` stays 0.
- Reset, then `o_rd` with no preceding `o_astb` → `err` = 1 next cycle and stays 1 until `reset_n` is low for one edge.
- Batch of 3 writes starting at 'hffffe → writes land at 'hffffe, 'hfffff, 'h00000 (wrap); reads at 'hffffe return `laddr`, not stored data.
